// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: hex-digit segment table {g,f,e,d,c,b,a} and scan defaults.
package sseg_pkg;

    localparam int NUM_DIGITS_DEF = 4;

    // Entry k is the active-high segment pattern for hex digit k.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        return SEG_TABLE[h];
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational reverse lookup of an active-high segment code into a hex digit.
// Zero latency; no backpressure. hit=0 when bits [6:0] match no table entry.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [7:0] code,
    output logic [3:0] hex,
    output logic       dp,
    output logic       hit
);

    always_comb begin
        hex = '0;
        hit = 1'b0;
        dp  = code[7];
        for (int k = 0; k < 16; k++) begin
            if (code[6:0] == SEG_TABLE[k]) begin
                hex = 4'(k);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers per-digit hex values from a scanned 7-segment display bus with debounce-style acceptance.
// Latency: 2 edges from an[i] falling to hex update; purely observing, no backpressure.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    active_high,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [7:0]              sseg,
    output logic [4*NUM_DIGITS-1:0] hex,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    update
);

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [NUM_DIGITS-1:0] r_an;
    logic [7:0]            r_sseg;
    // A digit may only be strobed after an[i] has been seen low since reset,
    // so a strobe interrupted by reset never produces a capture.
    logic [NUM_DIGITS-1:0] armed;

    logic [3:0]            cand_hex [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] cand_dp;
    logic [3:0]            cnt      [NUM_DIGITS];
    logic [3:0]            cnt_nxt  [NUM_DIGITS];

    logic                  multi_hot;
    logic [NUM_DIGITS-1:0] capture;
    logic [NUM_DIGITS-1:0] load;
    logic [7:0]            norm;
    logic [3:0]            dec_hex;
    logic                  dec_dp;
    logic                  dec_hit;

    assign multi_hot = |(an & (an - NUM_DIGITS'(1)));
    assign capture   = r_an & ~an & {NUM_DIGITS{~multi_hot}};
    assign norm      = active_high ? r_sseg : ~r_sseg;

    sseg_pattern_decode u_decode (
        .code (norm),
        .hex  (dec_hex),
        .dp   (dec_dp),
        .hit  (dec_hit)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cnt_nxt[i] = 4'd1;
            load[i]    = 1'b0;
            if (cand_hex[i] == dec_hex && cand_dp[i] == dec_dp) begin
                cnt_nxt[i] = (cnt[i] >= STABLE) ? STABLE : cnt[i] + 4'd1;
            end
            if (capture[i] && dec_hit && cnt_nxt[i] == STABLE &&
                (!valid[i] || hex[4*i +: 4] != dec_hex || dp[i] != dec_dp)) begin
                load[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an    <= '0;
            r_sseg  <= '0;
            armed   <= ~an;
            hex     <= '0;
            dp      <= '0;
            valid   <= '0;
            err     <= '0;
            update  <= 1'b0;
            cand_dp <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand_hex[i] <= '0;
                cnt[i]      <= '0;
            end
        end else begin
            r_sseg <= sseg;
            r_an   <= multi_hot ? '0 : (an & armed);
            armed  <= armed | ~an;
            update <= |load;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture[i]) begin
                    if (dec_hit) begin
                        err[i]      <= 1'b0;
                        cand_hex[i] <= dec_hex;
                        cand_dp[i]  <= dec_dp;
                        cnt[i]      <= cnt_nxt[i];
                        if (load[i]) begin
                            hex[4*i +: 4] <= dec_hex;
                            dp[i]         <= dec_dp;
                            valid[i]      <= 1'b1;
                        end
                    end else begin
                        err[i] <= 1'b1;
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of scanned digits (1..8).
REQ-002 The block SHALL have parameter STABLE_CNT, default 3, giving the consecutive identical captures needed to accept a digit value (1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port active_high, input, 1 bit: segment polarity; 1 = lit segment is 1, 0 = lit segment is 0.
REQ-006 The block SHALL have port an, input, NUM_DIGITS bits: digit strobes, active-high, nominally one-hot or zero.
REQ-007 The block SHALL have port sseg, input, 8 bits: segment bus {dp,g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port hex, output, 4*NUM_DIGITS bits: accepted value per digit; digit i in hex[4i+3:4i].
REQ-009 The block SHALL have port dp, output, NUM_DIGITS bits: accepted decimal point per digit.
REQ-010 The block SHALL have port valid, output, NUM_DIGITS bits: digit i has an accepted value.
REQ-011 The block SHALL have port err, output, NUM_DIGITS bits: the last capture of digit i was not a legal pattern.
REQ-012 The block SHALL have port update, output, 1 bit: one-cycle pulse after any accepted value changes.

Function
REQ-013 The block SHALL register an and sseg into r_an and r_sseg every cycle (input stage).
REQ-014 A multi-hot an SHALL load r_an with 0 and suppress all captures that cycle.
REQ-015 A capture of digit i SHALL occur at the edge where r_an[i]=1 and an[i]=0, using r_sseg.
REQ-016 The captured code SHALL be normalized as r_sseg if active_high=1, else ~r_sseg.
REQ-017 Normalized bits [6:0] SHALL be matched exactly against the 16-entry hex table (0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:67 A:77 B:7C C:39 D:5E E:79 F:71); bit 7 is dp.
REQ-018 Per digit, the block SHALL hold a candidate {hex,dp} and a saturating count (0..STABLE_CNT).
REQ-019 On a legal capture equal to the candidate, count SHALL increment and saturate at STABLE_CNT.
REQ-020 On a legal capture differing from the candidate, the block SHALL load the candidate and set count to 1.
REQ-021 On an illegal capture, the block SHALL set count to 0 and err[i] to 1, leaving hex, dp and valid unchanged.
REQ-022 A legal capture SHALL clear err[i] at the capture edge.
REQ-023 At the capture edge where count reaches STABLE_CNT, the block SHALL load hex/dp from the candidate and set valid[i] if valid[i]=0 or the value differs.
REQ-024 update SHALL be high for exactly the cycle after any REQ-023 load; simultaneous loads on several digits SHALL give one pulse.
REQ-025 A change of active_high SHALL NOT reset counts or candidates.
REQ-026 Latency SHALL be 2 edges from the an[i] falling edge to the hex change: one for the input stage, one for the capture.

Reset
REQ-027 While rst_n=0 at an edge, the block SHALL clear hex, dp, valid, err, update, r_an, r_sseg, candidates and counts to 0.
REQ-028 A reset mid-strobe SHALL discard the strobe, with no capture until a fresh 1->0 strobe transition.

Structure
REQ-029 Package sseg_pkg SHALL hold the 16-entry segment table constant (shared with the seg7 encoder) and the NUM_DIGITS default.
REQ-030 Pattern matching SHALL be in the combinational sub-module sseg_pattern_decode (8-bit code -> hex, dp, hit), instantiated once on the normalized r_sseg.

Verification
REQ-031 active_high=1, digit 0 strobed 3x with sseg=8'h3F -> hex[3:0]=0, valid[0]=1, one update pulse after the 3rd strobe; further identical strobes give no pulse.
REQ-032 active_high=0, digit 2 strobed 3x with sseg=8'h79 -> hex[11:8]=1, dp[2]=1, valid[2]=1.
REQ-033 Digit 1 captures 5B,5B,4F,4F,4F -> no accept after the 2nd; hex[7:4]=3 after the 5th, with a single update pulse.
REQ-034 Digit 3 strobed with sseg=8'h00 (active_high=1) -> err[3]=1, valid and hex unchanged; a following 8'h06 strobe clears err[3].
REQ-035 an=4'b0011 held then dropped to 0 -> no capture, count unchanged.
REQ-036 rst_n=0 for one cycle mid-strobe after a digit was valid -> all outputs 0; no capture at that strobe's fall.
